// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its entry FIFO.
package instr_fetch_unit_pkg;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [ADDR_W-1:0]  PC_STEP          = 32'h0000_0004;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush clears occupancy, pop and push may share a cycle.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [ENTRY_W-1:0]       i_wdata,
  output logic [ENTRY_W-1:0]       o_rdata,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_do_pop;
  logic               w_do_push;

  assign o_full    = (r_count == CNT_MAX);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && (r_count != {CW{1'b0}});
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage, pointers and occupancy; flush drops every entry without touching storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {ENTRY_W{1'b0}};
      end
    end else if (i_flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns fetch PC, buffers same-cycle memory reads, applies redirects.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  w_redirect_target;
  logic               w_fault;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic [CW-1:0]      w_count;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_wdata;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  // Fault latches on a misaligned redirect and persists until the next redirect or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_fault <= |redirect_pc[1:0];
    end else begin
      r_fault <= r_fault;
    end
  end

  assign w_fault           = r_fault;
  assign w_redirect_target = redirect_pc;
`else
  assign w_fault           = 1'b0;
  assign w_redirect_target = word_align(redirect_pc);
`endif

  assign w_pop   = out_valid && out_ready;
  assign w_push  = !rst && !redirect_valid && !w_fault && (!w_full || w_pop);
  assign w_wdata = {r_fetch_pc, imem_rdata};

  // Fetch PC: redirect beats sequential advance; holds while the buffer cannot accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_target;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + PC_STEP;
    end else begin
      r_fetch_pc <= r_fetch_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // While faulted the FIFO is empty, so the faulting PC itself is presented with a NOP.
  assign imem_addr = r_fetch_pc;
  assign out_valid = (w_count != {CW{1'b0}}) | w_fault;
  assign out_pc    = w_fault ? r_fetch_pc : w_head[ENTRY_W-1:INSTR_W];
  assign out_instr = w_fault ? NOP_INSTR : w_head[INSTR_W-1:0];
  assign out_fault = w_fault;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic against a queue model.
module tb_instr_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_fault;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  instr_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic bit exp_valid();
    return (m_q.size() != 0) || m_fault;
  endfunction

  function automatic logic [31:0] exp_pc();
    if (m_fault) return m_pc;
    if (m_q.size() != 0) return m_q[0];
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_instr();
    if (m_fault) return NOP;
    if (m_q.size() != 0) return mem_word(m_q[0]);
    return 32'h0;
  endfunction

  // Reference: one clock of the fetch rules applied to the current inputs.
  task automatic model_step();
    bit pop;
    if (rst) begin
      m_q.delete();
      m_pc    = RPC;
      m_fault = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc    = redirect_pc;
      m_fault = (redirect_pc[1:0] != 2'b00);
`else
      m_pc    = {redirect_pc[31:2], 2'b00};
      m_fault = 1'b0;
`endif
    end else begin
      pop = exp_valid() && out_ready;
      if (pop && m_q.size() != 0) void'(m_q.pop_front());
      if (!m_fault && m_q.size() < DEPTH) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", out_valid); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b exp 0", out_fault); end
    checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL reset_addr: got %h exp %h", imem_addr, RPC); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", out_instr); end
  endtask

  task automatic test_stream();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b exp 1", i, out_valid); end
      checks++; if (out_pc !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc[%0d]: got %h exp %h", i, out_pc, 32'(i * 4)); end
      checks++; if (out_instr !== mem_word(32'(i * 4))) begin errors++; $display("FAIL stream_instr[%0d]: got %h exp %h", i, out_instr, mem_word(32'(i * 4))); end
      checks++; if (imem_addr !== 32'((i + 1) * 4)) begin errors++; $display("FAIL stream_addr[%0d]: got %h exp %h", i, imem_addr, 32'((i + 1) * 4)); end
    end
  endtask

  task automatic test_backpressure();
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b0;
    repeat (5) tick();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr_hold: got %h exp 00000008", imem_addr); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%0b pc=%h exp v=1 pc=0", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin errors++; $display("FAIL bp_drain[%0d]: got v=%0b pc=%h exp pc=%h", i, out_valid, out_pc, 32'(i * 4)); end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    out_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h3C;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdfull_valid: got %0b exp 0", out_valid); end
    checks++; if (imem_addr !== 32'h3C) begin errors++; $display("FAIL rdfull_addr: got %h exp 0000003c", imem_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3C) begin errors++; $display("FAIL rdfull_pc: got v=%0b pc=%h exp pc=0000003c", out_valid, out_pc); end
    checks++; if (out_instr !== mem_word(32'h3C)) begin errors++; $display("FAIL rdfull_instr: got %h exp %h", out_instr, mem_word(32'h3C)); end
  endtask

  task automatic test_redirect_pop();
    bit found = 1'b0;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (out_valid === 1'b1 && out_pc === 32'h10) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rdpop_reach_head: got no head 00000010 exp head 00000010"); end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdpop_valid: got %0b exp 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(32'h80 + i * 4)) begin errors++; $display("FAIL rdpop_seq[%0d]: got v=%0b pc=%h exp pc=%h", i, out_valid, out_pc, 32'(32'h80 + i * 4)); end
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid: got %0b exp 0", out_valid); end
    tick();
    checks++; if (out_pc !== 32'hFFFF_FFFC || out_instr !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_top: got pc=%h instr=%h exp pc=fffffffc", out_pc, out_instr); end
    tick();
    checks++; if (out_pc !== 32'h0 || out_instr !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_zero: got pc=%h instr=%h exp pc=0", out_pc, out_instr); end
  endtask

  task automatic test_misalign();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3E;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1) begin errors++; $display("FAIL mis_fault[%0d]: got v=%0b f=%0b exp 1 1", i, out_valid, out_fault); end
      checks++; if (out_pc !== 32'h3E || out_instr !== NOP) begin errors++; $display("FAIL mis_entry[%0d]: got pc=%h instr=%h exp 0000003e 00000013", i, out_pc, out_instr); end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_fault !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mis_clear: got v=%0b f=%0b exp 0 0", out_valid, out_fault); end
    tick();
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL mis_resume: got %h exp 00000100", out_pc); end
`else
    checks++; if (out_valid !== 1'b0 || out_fault !== 1'b0) begin errors++; $display("FAIL mis_nofault: got v=%0b f=%0b exp 0 0", out_valid, out_fault); end
    tick();
    checks++; if (out_pc !== 32'h3C || out_fault !== 1'b0) begin errors++; $display("FAIL mis_aligned: got pc=%h f=%0b exp 0000003c 0", out_pc, out_fault); end
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; redirect_valid = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %0b exp 1", out_valid); end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || imem_addr !== RPC) begin errors++; $display("FAIL rstmid: got v=%0b addr=%h exp 0 %h", out_valid, imem_addr, RPC); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 49) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = $urandom() & (($urandom_range(0, 3) == 0) ? 32'h0000_0FFF : 32'h0000_0FFC);
      out_ready      = ($urandom_range(0, 2) != 0);
      tick();
      checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid[%0d]: got %0b exp %0b", i, out_valid, exp_valid()); end
      checks++; if (out_fault !== m_fault) begin errors++; $display("FAIL rnd_fault[%0d]: got %0b exp %0b", i, out_fault, m_fault); end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h exp %h", i, imem_addr, m_pc); end
      if (exp_valid()) begin
        checks++; if (out_pc !== exp_pc() || out_instr !== exp_instr()) begin errors++; $display("FAIL rnd_entry[%0d]: got pc=%h instr=%h exp pc=%h instr=%h", i, out_pc, out_instr, exp_pc(), exp_instr()); end
      end
    end
    rst = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
